// File: rtl/sequential_divider.sv
// Unsigned restoring shift-and-subtract divider, one quotient bit per clock.
// Start/ready handshake with IDLE/WORKING/DONE control; divide-by-zero completes early.
module sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    // state   | meaning
    // IDLE    | waiting for start
    // WORKING | one restoring step per clock, counter counts down to 0
    // DONE    | result valid, start restarts like IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t          state, state_next;
    logic [CW-1:0]   counter;
    logic [WIDTH:0]  a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic            dz_reg;
    logic            accept;
    logic            step;
    logic [WIDTH:0]  shifted;
    logic [WIDTH:0]  trial;

    assign shifted = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, m_reg};

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                ready = (state == DONE);
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : WORKING;
                end
            end
            WORKING: begin
                busy = 1'b1;
                step = 1'b1;
                if (counter == '0) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            counter <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            dz_reg  <= 1'b0;
        end else if (accept) begin
            counter <= CW'(WIDTH - 1);
            m_reg   <= divisor;
            dz_reg  <= (divisor == '0);
            if (divisor == '0) begin
                a_reg <= {1'b0, dividend};
                q_reg <= '1;
            end else begin
                a_reg <= '0;
                q_reg <= dividend;
            end
        end else if (step) begin
            // A negative trial difference means the divisor did not fit: restore.
            a_reg <= trial[WIDTH] ? shifted : trial;
            q_reg <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
            if (counter != '0) begin
                counter <= counter - CW'(1);
            end
        end
    end

    assign quotient    = q_reg;
    assign remainder   = a_reg[WIDTH-1:0];
    assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (WIDTH=8): hand-computed vectors,
// handshake latency, mid-operation start/operand changes and async reset abort.
module tb_sequential_divider;

    logic       clock;
    logic       n_reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       busy;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    int busy_n;
    logic first_ready;
    logic glitch = 1'b0;

    sequential_divider #(.WIDTH(8)) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one accepting edge, then sample on negedges until ready (bounded).
    task automatic launch(input logic [7:0] dd, input logic [7:0] dv);
        @(negedge clock);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat    = 0;
        busy_n = 0;
        first_ready = 1'bx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (i == 1) first_ready = ready;
            if (glitch && i == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end
            if (glitch && i == 5) start = 1'b0;
            if (busy) busy_n++;
            if (ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                       input int eq, input int er, input int ez, input int elat, input int ebusy);
        launch(dd, dv);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_busy_cycles"}, busy_n, ebusy);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_div_by_zero"}, div_by_zero, ez);
        if (ez == 0) check({tag, "_ready_drops"}, first_ready, 0);
    endtask

    initial begin
        n_reset  = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #3;
        check("reset_ready", ready, 0);
        check("reset_busy", busy, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_div_by_zero", div_by_zero, 0);
        #20 n_reset = 1'b1;

        run("d100_7", 8'd100, 8'd7, 14, 2, 0, 9, 8);

        // Result must hold in DONE while start stays low.
        repeat (5) @(negedge clock);
        check("hold_ready", ready, 1);
        check("hold_quotient", quotient, 14);
        check("hold_remainder", remainder, 2);

        run("d255_1", 8'd255, 8'd1, 255, 0, 0, 9, 8);
        run("d5_9", 8'd5, 8'd9, 0, 5, 0, 9, 8);
        run("d42_0", 8'd42, 8'd0, 255, 42, 1, 1, 0);
        run("d200_10", 8'd200, 8'd10, 20, 0, 0, 9, 8);
        run("d0_13", 8'd0, 8'd13, 0, 0, 0, 9, 8);
        run("d255_255", 8'd255, 8'd255, 1, 0, 0, 9, 8);
        run("d254_255", 8'd254, 8'd255, 0, 254, 0, 9, 8);
        run("d255_16", 8'd255, 8'd16, 15, 15, 0, 9, 8);
        run("d128_2", 8'd128, 8'd2, 64, 0, 0, 9, 8);

        glitch = 1'b1;
        run("ignore_start", 8'd100, 8'd7, 14, 2, 0, 9, 8);
        glitch = 1'b0;

        // Async reset part-way through a division.
        @(negedge clock);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_busy", busy, 1);
        #2 n_reset = 1'b0;
        #1;
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_div_by_zero", div_by_zero, 0);
        #12 n_reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset_idle_busy", busy, 0);
        check("post_reset_idle_ready", ready, 0);
        run("d200_3", 8'd200, 8'd3, 66, 2, 0, 9, 8);

        for (int k = 0; k < 200; k++) begin
            logic [7:0] dd, dv;
            dd = 8'($urandom_range(0, 255));
            dv = 8'($urandom_range(0, 255));
            if (k % 25 == 0) dv = 8'd0;
            launch(dd, dv);
            if (dv == 8'd0) begin
                check("rand_dz_quotient", quotient, 255);
                check("rand_dz_remainder", remainder, dd);
                check("rand_dz_flag", div_by_zero, 1);
                check("rand_dz_latency", lat, 1);
            end else begin
                check("rand_quotient", quotient, dd / dv);
                check("rand_remainder", remainder, dd % dv);
                check("rand_flag", div_by_zero, 0);
                check("rand_latency", lat, 9);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
